stream_demux: RTL and testbench

//  Handshaked 1-to-N demultiplexer: routes each {in_sel, in_data} beat to exactly one of OUTPUT

---
 rtl/mux_pkg.sv | 10 +
 rtl/sync_fifo2.sv | 47 ++++
 rtl/stream_demux.sv | 68 ++++++
 tb/tb_stream_demux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and the beat entry layout used by the stream mux/demux blocks.
package mux_pkg;
   localparam int DEF_OUTPUT = 8;
   localparam int DEF_WIDTH  = 32;
   // Entry layout at the default sizes; parameterised blocks declare their own copy with the same fields.
   typedef struct packed {
      logic [$clog2(DEF_OUTPUT)-1:0] sel;
      logic [DEF_WIDTH-1:0]          data;
   } demux_entry_t;
endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2: two-entry synchronous FIFO with head-first read, push and pop allowed in the same cycle.
module sync_fifo2 import mux_pkg::*; #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   count_q, count_d, pos;
   logic         push_ok, pop_ok;

   always_comb begin
      pop_ok  = pop & (count_q != 2'd0);
      push_ok = push & (count_q != 2'd2);
      // slot the new beat lands in once any pop has shifted the tail forward
      pos     = count_q - {1'b0, pop_ok};
      head_d  = pop_ok ? tail_q : head_q;
      tail_d  = tail_q;
      if (push_ok && pos == 2'd0) head_d = din;
      if (push_ok && pos == 2'd1) tail_d = din;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign count = count_q;
   assign full  = count_q == 2'd2;
   assign empty = count_q == 2'd0;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: handshaked 1-to-N demultiplexer; buffers up to two beats and steers the head to its lane.
module stream_demux import mux_pkg::*; #(
   parameter int OUTPUT    = DEF_OUTPUT,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SEL_WIDTH = $clog2(OUTPUT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_data_i,
   input  logic [SEL_WIDTH-1:0] in_sel_i,
   output logic [OUTPUT-1:0]    out_valid_o,
   input  logic [OUTPUT-1:0]    out_ready_i,
   output logic [WIDTH-1:0]     out_data_o,
   output logic                 sel_err_o
);
   localparam logic [SEL_WIDTH:0] OUT_LIM = OUTPUT[SEL_WIDTH:0];

   typedef struct packed {
      logic [SEL_WIDTH-1:0] sel;
      logic [WIDTH-1:0]     data;
   } entry_t;

   entry_t     din, dout;
   logic [1:0] count, count_d;
   logic       full, empty, sel_ok, accept, push, pop;
   logic       in_ready_q, in_ready_d, sel_err_q, sel_err_d;

   sync_fifo2 #(.W($bits(entry_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      sel_ok     = {1'b0, in_sel_i} < OUT_LIM;
      accept     = in_valid_i & in_ready_q;
      // out-of-range beats are consumed from the producer but never stored
      push       = accept & sel_ok & ~full;
      pop        = ~empty & out_ready_i[dout.sel];
      count_d    = count + {1'b0, push} - {1'b0, pop};
      in_ready_d = count_d != 2'd2;
      sel_err_d  = accept & ~sel_ok;
      din        = '{sel: in_sel_i, data: in_data_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         in_ready_q <= in_ready_d;
         sel_err_q  <= sel_err_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign sel_err_o   = sel_err_q;
   assign out_valid_o = empty ? '0 : {{(OUTPUT-1){1'b0}}, 1'b1} << dout.sel;
   assign out_data_o  = empty ? '0 : dout.data;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: drives an 8-lane and a 5-lane demux with the same stream and checks both against queue models.
module tb_stream_demux;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [2:0]  in_sel = '0;
   logic [7:0]  out_ready = '1;
   logic        in_ready8, in_ready5, sel_err8, sel_err5;
   logic [7:0]  ov8;
   logic [4:0]  ov5;
   logic [31:0] od8, od5;

   int total = 0;
   int bad = 0;
   logic [34:0] q8[$];
   logic [34:0] q5[$];
   logic rdy8 = 1'b0, rdy5 = 1'b0, err8 = 1'b0, err5 = 1'b0;

   always #5 clk = ~clk;

   stream_demux #(.OUTPUT(8), .WIDTH(32)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready8),
      .in_data_i(in_data), .in_sel_i(in_sel), .out_valid_o(ov8), .out_ready_i(out_ready),
      .out_data_o(od8), .sel_err_o(sel_err8)
   );

   stream_demux #(.OUTPUT(5), .WIDTH(32)) u5 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready5),
      .in_data_i(in_data), .in_sel_i(in_sel), .out_valid_o(ov5), .out_ready_i(out_ready[4:0]),
      .out_data_o(od5), .sel_err_o(sel_err5)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour at a clock edge: head leaves if its lane is ready, accepted in-range beats join the tail.
   task automatic model_edge();
      logic a8, a5;
      if (!rst_n) begin
         q8.delete(); q5.delete();
         rdy8 = 0; rdy5 = 0; err8 = 0; err5 = 0;
         return;
      end
      a8 = in_valid && rdy8;
      a5 = in_valid && rdy5;
      if (q8.size() > 0 && out_ready[q8[0][34:32]]) void'(q8.pop_front());
      if (q5.size() > 0 && out_ready[q5[0][34:32]]) void'(q5.pop_front());
      err8 = a8 && (int'(in_sel) >= 8);
      err5 = a5 && (int'(in_sel) >= 5);
      if (a8 && !err8) q8.push_back({in_sel, in_data});
      if (a5 && !err5) q5.push_back({in_sel, in_data});
      rdy8 = q8.size() < 2;
      rdy5 = q5.size() < 2;
   endtask

   task automatic check_all(input string tag);
      logic [7:0]  e8;
      logic [4:0]  e5;
      logic [31:0] d8, d5;
      e8 = q8.size() > 0 ? 8'd1 << q8[0][34:32] : 8'd0;
      e5 = q5.size() > 0 ? 5'd1 << q5[0][34:32] : 5'd0;
      d8 = q8.size() > 0 ? q8[0][31:0] : 32'd0;
      d5 = q5.size() > 0 ? q5[0][31:0] : 32'd0;
      chk({tag, "/ov8"}, ov8, e8);
      chk({tag, "/od8"}, od8, d8);
      chk({tag, "/rdy8"}, in_ready8, rdy8);
      chk({tag, "/err8"}, sel_err8, err8);
      chk({tag, "/ov5"}, ov5, e5);
      chk({tag, "/od5"}, od5, d5);
      chk({tag, "/rdy5"}, in_ready5, rdy5);
      chk({tag, "/err5"}, sel_err5, err5);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // reset held with a pending beat: nothing may be accepted
      in_valid = 1; in_sel = 0; in_data = 32'hdead;
      repeat (3) step("rst");
      chk("rst_rdy8", in_ready8, 1'b0);
      rst_n = 1;
      step("rel");
      chk("rel_rdy8", in_ready8, 1'b1);
      chk("rel_ov8", ov8, 8'd0);
      in_valid = 0;
      step("idle");

      // one beat per lane, no bubbles
      out_ready = '1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_sel = 3'(i); in_data = 32'(i);
         step("sweep");
         chk("sweep_ov8", ov8, 8'd1 << i);
         chk("sweep_od8", od8, 32'(i));
         chk("sweep_rdy8", in_ready8, 1'b1);
      end
      in_valid = 0;
      step("drain");

      // backpressure: two beats fit, third waits
      out_ready = '0; in_valid = 1;
      in_sel = 2; in_data = 32'ha2; step("bp0");
      in_sel = 5; in_data = 32'ha5; step("bp1");
      in_sel = 7; in_data = 32'ha7; step("bp2");
      chk("bp_full_rdy8", in_ready8, 1'b0);
      chk("bp_head_ov8", ov8, 8'b0000_0100);
      out_ready = 8'b0000_0100;
      step("bp_pop2");
      chk("bp_rdy_back", in_ready8, 1'b1);
      chk("bp_ov5", ov8, 8'b0010_0000);
      chk("bp_od5", od8, 32'ha5);
      step("bp_acc7");
      in_valid = 0; out_ready = '1;
      step("bp_pop5");
      chk("bp_ov7", ov8, 8'b1000_0000);
      chk("bp_od7", od8, 32'ha7);
      step("bp_pop7");
      chk("bp_empty", ov8, 8'd0);

      // push and pop together at count 1
      out_ready = '0; in_valid = 1; in_sel = 3; in_data = 32'hb3;
      step("pp0");
      out_ready = '1; in_sel = 4; in_data = 32'hb4;
      step("pp1");
      chk("pp_ov8", ov8, 8'b0001_0000);
      chk("pp_od8", od8, 32'hb4);
      chk("pp_rdy8", in_ready8, 1'b1);
      in_valid = 0;
      step("pp_drain");
      chk("pp_empty", ov8, 8'd0);

      // out-of-range lane on the 5-lane instance
      in_valid = 1; in_sel = 6; in_data = 32'hc6;
      step("oor6");
      chk("oor_err5", sel_err5, 1'b1);
      chk("oor_ov5", ov5, 5'd0);
      in_sel = 4; in_data = 32'hc4;
      step("oor4");
      chk("oor_err5_clr", sel_err5, 1'b0);
      chk("oor_ov5_l4", ov5, 5'b10000);
      chk("oor_od5", od5, 32'hc4);
      in_valid = 0;
      step("oor_drain");

      // asynchronous reset with two beats buffered
      out_ready = '0; in_valid = 1;
      in_sel = 1; in_data = 32'hd1; step("mr0");
      in_sel = 6; in_data = 32'hd6; step("mr1");
      in_valid = 0;
      #2 rst_n = 0;
      q8.delete(); q5.delete();
      rdy8 = 0; rdy5 = 0; err8 = 0; err5 = 0;
      #1;
      chk("mr_ov8", ov8, 8'd0);
      chk("mr_ov5", ov5, 5'd0);
      chk("mr_od8", od8, 32'd0);
      chk("mr_rdy8", in_ready8, 1'b0);
      step("mr_hold");
      rst_n = 1; out_ready = '1;
      repeat (3) step("mr_after");

      // random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid = 1'($urandom_range(0, 3) != 0);
         in_sel = 3'($urandom_range(0, 7));
         in_data = $urandom;
         out_ready = 8'($urandom | $urandom);
         step("rnd");
      end
      in_valid = 0; out_ready = '1;
      repeat (3) step("rnd_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
